led_mode_sequencer: RTL and testbench

Sequences the board's green LED bank from a shared blink timebase derived from `CLOCK_50`. Provides four display modes and applies mode changes only on tick boundaries. Requesters use a req/ack handshake, so LED patterns never glitch mid-period. Sits between user-input logic (switch/key decoding) and the `LEDG` pins.

---
 rtl/led_ctrl_pkg.sv | 29 ++
 rtl/led_tick_gen.sv | 47 ++++
 rtl/led_mode_sequencer.sv | 89 ++++++++
 tb/tb_led_mode_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared types for the LED mode sequencer: display modes, FSM state codes and
// the per-mode initial pattern.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_BLINK = 2'd1,
        MODE_CHASE = 2'd2,
        MODE_FILL  = 2'd3
    } mode_t;

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_PEND = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    localparam int unsigned MAX_LED = 64;

    // Callers truncate the result to their own bank width (n_led <= MAX_LED).
    function automatic logic [MAX_LED-1:0] init_pattern(input mode_t mode, input int unsigned n_led);
        logic [MAX_LED-1:0] pat;
        case (mode)
            MODE_OFF:   pat = '0;
            MODE_BLINK: pat = {MAX_LED{1'b1}} >> (MAX_LED - n_led);
            default:    pat = {{(MAX_LED-1){1'b0}}, 1'b1};
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Blink timebase: free-running divider producing a one-cycle tick per period.
// With LED_SPEED_SEL_EN the divisor is DIV >> speed_sel, re-sampled at each wrap.
module led_tick_gen #(
    parameter int DIV = 16
) (
    input  logic       clk,
    input  logic       rst_n,
`ifdef LED_SPEED_SEL_EN
    input  logic [1:0] speed_sel,
`endif
    output logic       tick
);

    localparam int CW = $clog2(DIV);

    logic [CW-1:0] count;
    logic          wrap;

`ifdef LED_SPEED_SEL_EN
    logic [CW-1:0] last_q;

    // The new divisor only takes over at a wrap so a running period is never cut short.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_q <= CW'(DIV - 1);
        else if (wrap)
            last_q <= CW'((DIV >> speed_sel) - 1);
    end

    assign wrap = (count == last_q);
`else
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    assign wrap = (count == LAST);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            count <= wrap ? '0 : count + 1'b1;
            tick  <= wrap;
        end
    end

endmodule

// File: rtl/led_mode_sequencer.sv
// LEDG bank sequencer: four display modes stepped by a shared tick, with mode
// changes taken through a req/ack handshake. Optional LED_SPEED_SEL_EN adds speed_sel.
module led_mode_sequencer
    import led_ctrl_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 2,
    parameter int N_LED   = 8
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic             mode_req,
    input  logic [1:0]       mode_sel,
`ifdef LED_SPEED_SEL_EN
    input  logic [1:0]       speed_sel,
`endif
    output logic             mode_ack,
    output logic             tick,
    output logic [1:0]       cur_mode,
    output logic [N_LED-1:0] LEDG
);

    localparam int DIV = CLK_HZ / TICK_HZ;

    logic [1:0]       state;
    mode_t            pend_mode;
    mode_t            mode_q;
    logic [N_LED-1:0] pattern;
    logic [N_LED-1:0] step;

    led_tick_gen #(.DIV(DIV)) u_tick (
        .clk      (CLOCK_50),
        .rst_n    (RESET_N),
`ifdef LED_SPEED_SEL_EN
        .speed_sel(speed_sel),
`endif
        .tick     (tick)
    );

    always_comb begin
        step = pattern;
        case (mode_q)
            MODE_OFF:   step = '0;
            MODE_BLINK: step = ~pattern;
            MODE_CHASE: step = {pattern[N_LED-2:0], pattern[N_LED-1]};
            MODE_FILL:  step = (&pattern) ? '0 : {pattern[N_LED-2:0], 1'b1};
            default:    step = pattern;
        endcase
    end

    // A latched request waits in PEND for the tick edge, so the display only changes on a step.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= ST_RUN;
            pend_mode <= MODE_OFF;
            mode_q    <= MODE_OFF;
            pattern   <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (mode_req && !mode_ack) begin
                        pend_mode <= mode_t'(mode_sel);
                        state     <= ST_PEND;
                    end
                    if (tick)
                        pattern <= step;
                end
                ST_PEND: begin
                    if (tick) begin
                        mode_q  <= pend_mode;
                        pattern <= N_LED'(init_pattern(pend_mode, N_LED));
                        state   <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    state <= ST_RUN;
                    if (tick)
                        pattern <= step;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    assign mode_ack = (state == ST_ACK);
    assign cur_mode = mode_q;
    assign LEDG     = pattern;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Self-checking bench for led_mode_sequencer (DIV=16, 8 LEDs): per-cycle model
// comparison plus directed literal checks of each mode and handshake corner.
module tb_led_mode_sequencer;

    localparam int DIV = 16;

    logic       CLOCK_50 = 1'b0;
    logic       RESET_N  = 1'b0;
    logic       mode_req = 1'b0;
    logic [1:0] mode_sel = 2'd0;
`ifdef LED_SPEED_SEL_EN
    logic [1:0] speed_sel = 2'd0;
`endif
    logic       mode_ack;
    logic       tick;
    logic [1:0] cur_mode;
    logic [7:0] LEDG;

    int compared   = 0;
    int mismatched = 0;
    bit started    = 1'b0;

    led_mode_sequencer #(.CLK_HZ(16), .TICK_HZ(1), .N_LED(8)) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .mode_req (mode_req),
        .mode_sel (mode_sel),
`ifdef LED_SPEED_SEL_EN
        .speed_sel(speed_sel),
`endif
        .mode_ack (mode_ack),
        .tick     (tick),
        .cur_mode (cur_mode),
        .LEDG     (LEDG)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: phase/period timebase, LED value as an integer
    int m_phase, m_period, m_mode, m_led, m_pmode;
    bit m_tick, m_ack, m_pend;

    function automatic int initLed(input int m);
        case (m)
            0:       return 0;
            1:       return 255;
            default: return 1;
        endcase
    endfunction

    function automatic int stepLed(input int m, input int led);
        case (m)
            0:       return 0;
            1:       return led ^ 255;
            2:       return ((led << 1) | (led >> 7)) & 255;
            default: return (led == 255) ? 0 : (((led << 1) | 1) & 255);
        endcase
    endfunction

    always @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            m_phase = 0; m_period = DIV; m_mode = 0; m_led = 0; m_pmode = 0;
            m_tick = 0; m_ack = 0; m_pend = 0;
        end else begin
            bit was_pend;
            bit new_ack;
            was_pend = m_pend;
            new_ack  = 0;
            if (m_pend && m_tick) begin
                m_mode  = m_pmode;
                m_led   = initLed(m_pmode);
                m_pend  = 0;
                new_ack = 1;
            end else if (m_tick) begin
                m_led = stepLed(m_mode, m_led);
            end
            if (!was_pend && !m_ack && mode_req) begin
                m_pend  = 1;
                m_pmode = int'(mode_sel);
            end
            m_ack  = new_ack;
            m_tick = (m_phase == m_period - 1);
            if (m_tick) begin
                m_phase = 0;
`ifdef LED_SPEED_SEL_EN
                m_period = DIV >> speed_sel;
`else
                m_period = DIV;
`endif
            end else begin
                m_phase++;
            end
        end
    end

    always @(negedge CLOCK_50) begin
        if (started) begin
            checkOutput("tick",     32'(tick),     32'(m_tick));
            checkOutput("mode_ack", 32'(mode_ack), 32'(m_ack));
            checkOutput("cur_mode", 32'(cur_mode), 32'(m_mode));
            checkOutput("LEDG",     32'(LEDG),     32'(m_led));
        end
    end

    task automatic applyStimulus(input logic req, input logic [1:0] sel);
        @(posedge CLOCK_50);
        #2;
        mode_req = req;
        mode_sel = sel;
    endtask

    task automatic waitAck(input string name, output int cycles);
        bit seen = 0;
        cycles = 0;
        while (!seen && cycles < 60) begin
            @(negedge CLOCK_50);
            cycles++;
            if (mode_ack) seen = 1;
        end
        if (!seen) checkOutput(name, 32'd0, 32'd1);
    endtask

    // Returns at the negedge one cycle after a tick, when the stepped pattern is visible.
    task automatic waitTick(input string name);
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge CLOCK_50);
            if (tick) seen = 1;
        end
        if (!seen) checkOutput(name, 32'd0, 32'd1);
        else @(negedge CLOCK_50);
    endtask

    task automatic measureGap(output int gap);
        gap = 0;
        do begin
            @(negedge CLOCK_50);
            gap++;
        end while (!tick && gap < 40);
    endtask

    initial begin
        logic [7:0] chase_exp [8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
        logic [7:0] fill_exp  [9] = '{8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00, 8'h01};
        int cyc, ticks, acks;

        @(posedge CLOCK_50);
        started = 1'b1;
        repeat (2) @(posedge CLOCK_50);
        #2 RESET_N = 1'b1;

        ticks = 0; acks = 0;
        repeat (40) begin
            @(negedge CLOCK_50);
            if (tick) ticks++;
            if (mode_ack) acks++;
        end
        checkOutput("idle_ticks", 32'(ticks), 32'd2);
        checkOutput("idle_acks",  32'(acks),  32'd0);
        checkOutput("idle_led",   32'(LEDG),  32'h00);

        applyStimulus(1'b1, 2'd1);
        waitAck("blink_ack_timeout", cyc);
        checkOutput("blink_latency", 32'(cyc), 32'd10);
        checkOutput("blink_ack_led", 32'(LEDG), 32'hFF);
        checkOutput("blink_mode", 32'(cur_mode), 32'd1);
        applyStimulus(1'b0, 2'd1);
        waitTick("blink_tick1");
        checkOutput("blink_step1", 32'(LEDG), 32'h00);
        waitTick("blink_tick2");
        checkOutput("blink_step2", 32'(LEDG), 32'hFF);

        applyStimulus(1'b1, 2'd1);
        waitAck("reblink_ack_timeout", cyc);
        checkOutput("reblink_led", 32'(LEDG), 32'hFF);
        applyStimulus(1'b0, 2'd1);

        applyStimulus(1'b1, 2'd2);
        waitAck("chase_ack_timeout", cyc);
        checkOutput("chase_ack_led", 32'(LEDG), 32'h01);
        applyStimulus(1'b0, 2'd2);
        for (int i = 0; i < 8; i++) begin
            waitTick("chase_tick");
            checkOutput($sformatf("chase_step%0d", i), 32'(LEDG), 32'(chase_exp[i]));
        end

        applyStimulus(1'b1, 2'd3);
        waitAck("fill_ack_timeout", cyc);
        checkOutput("fill_ack_led", 32'(LEDG), 32'h01);
        applyStimulus(1'b0, 2'd3);
        for (int i = 0; i < 9; i++) begin
            waitTick("fill_tick");
            checkOutput($sformatf("fill_step%0d", i), 32'(LEDG), 32'(fill_exp[i]));
        end

        // Request lands in the tick cycle, then mode_sel moves while pending
        repeat (15) @(posedge CLOCK_50);
        #2;
        mode_req = 1'b1;
        mode_sel = 2'd2;
        applyStimulus(1'b1, 2'd1);
        waitAck("coinc_ack_timeout", cyc);
        checkOutput("coinc_latency", 32'(cyc), 32'd17);
        checkOutput("coinc_mode", 32'(cur_mode), 32'd2);
        checkOutput("coinc_led", 32'(LEDG), 32'h01);
        applyStimulus(1'b0, 2'd1);

        applyStimulus(1'b1, 2'd3);
        repeat (3) @(posedge CLOCK_50);
        #2;
        RESET_N  = 1'b0;
        mode_req = 1'b0;
        repeat (2) @(posedge CLOCK_50);
        #2 RESET_N = 1'b1;
        acks = 0;
        repeat (40) begin
            @(negedge CLOCK_50);
            if (mode_ack) acks++;
        end
        checkOutput("rst_acks", 32'(acks), 32'd0);
        checkOutput("rst_led",  32'(LEDG), 32'h00);
        checkOutput("rst_mode", 32'(cur_mode), 32'd0);

`ifdef LED_SPEED_SEL_EN
        measureGap(cyc);
        @(posedge CLOCK_50);
        #2 speed_sel = 2'd3;
        measureGap(cyc);
        checkOutput("speed_gap_current", 32'(cyc), 32'd16);
        measureGap(cyc);
        checkOutput("speed_gap_fast1", 32'(cyc), 32'd2);
        measureGap(cyc);
        checkOutput("speed_gap_fast2", 32'(cyc), 32'd2);
        @(posedge CLOCK_50);
        #2 speed_sel = 2'd0;
        repeat (4) @(negedge CLOCK_50);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
